// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter granting N_REQ requesters 4-phase write access to one shared register.
// Grant 1 cycle after request, commit + ack on the following edge, release when the winner drops req.
module reg_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic                   ack,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       qn,
  output logic                   busy,
  output logic [7:0]             wr_count
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, WRITE, RELEASE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] winner, last_served, pick, cand_idx;
  logic             pick_vld;
  logic [WIDTH-1:0] wsel;
  int               cand;

  // Walk offsets from farthest to nearest so the nearest requester above last_served wins.
  always_comb begin
    pick     = last_served;
    pick_vld = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand     = (int'(last_served) + i) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        pick     = cand_idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    wsel = wdata[int'(winner)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = GRANT;
      GRANT:   state_nxt = req[winner] ? WRITE : IDLE;
      WRITE:   state_nxt = RELEASE;
      RELEASE: if (!req[winner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner      <= '0;
      last_served <= IDX_W'(N_REQ - 1);
      q           <= '0;
      wr_count    <= '0;
    end else begin
      case (state)
        IDLE: if (pick_vld) winner <= pick;
        GRANT: begin
          if (req[winner]) begin
            q        <= wsel;
            wr_count <= wr_count + 8'd1;
          end else begin
            last_served <= winner;
          end
        end
        RELEASE: if (!req[winner]) last_served <= winner;
        default: ;
      endcase
    end
  end

  // Grant is derived from state so it is one-hot by construction and cleared by reset.
  always_comb begin
    gnt = '0;
    if (state != IDLE) gnt[winner] = 1'b1;
  end

  assign ack  = (state == WRITE);
  assign busy = (state != IDLE);
  assign qn   = ~q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed-vector bench for reg_share_arbiter: reset, single write, fairness, withdrawal, reset abort, ignored data, wrap.
module tb_reg_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic        ack;
  logic [7:0]  q;
  logic [7:0]  qn;
  logic        busy;
  logic [7:0]  wr_count;

  int n_pass  = 0;
  int n_total = 0;

  reg_share_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
    .gnt(gnt), .ack(ack), .q(q), .qn(qn), .busy(busy), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_wd(input int i, input logic [7:0] v);
    wdata[i*8 +: 8] = v;
  endtask

  task automatic do_reset;
    req   = 4'b0000;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req   = 4'b0000;
    wdata = 32'h0;
    #12;
    n_total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else n_pass++;
    n_total++; if (ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", ack); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (q !== 8'h00) $display("FAIL reset_q: got %h want 00", q); else n_pass++;
    n_total++; if (qn !== 8'hFF) $display("FAIL reset_qn: got %h want ff", qn); else n_pass++;
    n_total++; if (wr_count !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", wr_count); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    set_wd(0, 8'hA5);
    req = 4'b0001;
    tick;
    n_total++; if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", gnt); else n_pass++;
    n_total++; if (ack !== 1'b0) $display("FAIL single_ack_early: got %b want 0", ack); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
    tick;
    n_total++; if (q !== 8'hA5) $display("FAIL single_q: got %h want a5", q); else n_pass++;
    n_total++; if (qn !== 8'h5A) $display("FAIL single_qn: got %h want 5a", qn); else n_pass++;
    n_total++; if (ack !== 1'b1) $display("FAIL single_ack: got %b want 1", ack); else n_pass++;
    n_total++; if (wr_count !== 8'd1) $display("FAIL single_cnt: got %0d want 1", wr_count); else n_pass++;
    tick;
    n_total++; if (ack !== 1'b0) $display("FAIL single_ack_pulse: got %b want 0", ack); else n_pass++;
    n_total++; if (gnt !== 4'b0001) $display("FAIL single_hold: got %b want 0001", gnt); else n_pass++;
    req = 4'b0000;
    tick;
    n_total++; if (gnt !== 4'b0000) $display("FAIL single_release: got %b want 0000", gnt); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL single_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_fairness;
    logic [3:0] exp_g;
    int e;
    do_reset;
    for (int i = 0; i < 4; i++) set_wd(i, 8'h10 + 8'(i));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e     = k % 4;
      exp_g = 4'b0001 << e;
      tick;
      n_total++; if (gnt !== exp_g) $display("FAIL fair_gnt%0d: got %b want %b", k, gnt, exp_g); else n_pass++;
      tick;
      n_total++; if (ack !== 1'b1 || q !== 8'h10 + 8'(e)) $display("FAIL fair_write%0d: got ack=%b q=%h want ack=1 q=%h", k, ack, q, 8'h10 + 8'(e)); else n_pass++;
      tick;
      n_total++; if (gnt !== exp_g) $display("FAIL fair_nopreempt%0d: got %b want %b", k, gnt, exp_g); else n_pass++;
      req[e] = 1'b0;
      tick;
      n_total++; if (gnt !== 4'b0000) $display("FAIL fair_release%0d: got %b want 0000", k, gnt); else n_pass++;
      req[e] = 1'b1;
    end
    n_total++; if (wr_count !== 8'd5) $display("FAIL fair_cnt: got %0d want 5", wr_count); else n_pass++;
  endtask

  task automatic test_withdraw;
    req = 4'b0100;
    tick;
    n_total++; if (gnt !== 4'b0100) $display("FAIL wd_gnt: got %b want 0100", gnt); else n_pass++;
    req = 4'b0000;
    tick;
    n_total++; if (gnt !== 4'b0000 || ack !== 1'b0) $display("FAIL wd_drop: got gnt=%b ack=%b want 0000/0", gnt, ack); else n_pass++;
    n_total++; if (q !== 8'h10) $display("FAIL wd_q: got %h want 10", q); else n_pass++;
    n_total++; if (wr_count !== 8'd5) $display("FAIL wd_cnt: got %0d want 5", wr_count); else n_pass++;
    req = 4'b1111;
    tick;
    n_total++; if (gnt !== 4'b1000) $display("FAIL wd_next: got %b want 1000", gnt); else n_pass++;
    req = 4'b0000;
    tick;
    n_total++; if (gnt !== 4'b0000) $display("FAIL wd_clear: got %b want 0000", gnt); else n_pass++;
  endtask

  task automatic test_ignored_data;
    set_wd(1, 8'h77);
    req = 4'b0010;
    tick;
    tick;
    n_total++; if (q !== 8'h77) $display("FAIL ign_write: got %h want 77", q); else n_pass++;
    set_wd(0, 8'hEE);
    set_wd(2, 8'hEE);
    tick;
    n_total++; if (q !== 8'h77) $display("FAIL ign_nonwinner: got %h want 77", q); else n_pass++;
    set_wd(1, 8'h99);
    tick;
    n_total++; if (q !== 8'h77) $display("FAIL ign_release: got %h want 77", q); else n_pass++;
    req = 4'b0000;
    tick;
    tick;
    n_total++; if (q !== 8'h77 || wr_count !== 8'd6) $display("FAIL ign_idle: got q=%h cnt=%0d want 77/6", q, wr_count); else n_pass++;
  endtask

  task automatic test_reset_mid;
    set_wd(0, 8'h42);
    req = 4'b0001;
    tick;
    tick;
    n_total++; if (ack !== 1'b1 || q !== 8'h42) $display("FAIL rst_pre: got ack=%b q=%h want 1/42", ack, q); else n_pass++;
    #3 rst_n = 1'b0;
    #2;
    n_total++; if (gnt !== 4'b0000 || ack !== 1'b0 || busy !== 1'b0) $display("FAIL rst_async_ctl: got gnt=%b ack=%b busy=%b want 0000/0/0", gnt, ack, busy); else n_pass++;
    n_total++; if (q !== 8'h00 || qn !== 8'hFF) $display("FAIL rst_async_q: got q=%h qn=%h want 00/ff", q, qn); else n_pass++;
    n_total++; if (wr_count !== 8'd0) $display("FAIL rst_async_cnt: got %0d want 0", wr_count); else n_pass++;
    req = 4'b1111;
    @(negedge clk);
    n_total++; if (gnt !== 4'b0000) $display("FAIL rst_held: got %b want 0000", gnt); else n_pass++;
    rst_n = 1'b1;
    tick;
    n_total++; if (gnt !== 4'b0001) $display("FAIL rst_first_win: got %b want 0001", gnt); else n_pass++;
    req = 4'b0000;
    tick;
  endtask

  task automatic test_wrap;
    logic [7:0] v;
    do_reset;
    for (int i = 0; i < 256; i++) begin
      v = 8'(i) ^ 8'h3C;
      set_wd(1, v);
      req = 4'b0010;
      tick;
      tick;
      n_total++; if (wr_count !== 8'(i + 1) || q !== v) $display("FAIL wrap_step%0d: got cnt=%0d q=%h want %0d/%h", i, wr_count, q, 8'(i + 1), v); else n_pass++;
      req = 4'b0000;
      tick;
      tick;
    end
    n_total++; if (wr_count !== 8'd0) $display("FAIL wrap_cnt: got %0d want 0", wr_count); else n_pass++;
    n_total++; if (q !== 8'hC3 || qn !== 8'h3C) $display("FAIL wrap_q: got q=%h qn=%h want c3/3c", q, qn); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_withdraw;
    test_ignored_data;
    test_reset_mid;
    test_wrap;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
